// File: rtl/mailbox_msg.sv
// mailbox_msg: single-direction message mailbox with ownership hand-off.
//
// A producer fills up to MESSAGE_DEPTH slots and rings the doorbell (post).
// Ownership then passes to the consumer, which sees a level interrupt (irq),
// reads slots through a registered one-cycle-latency port and releases the
// mailbox with ack. Rejected accesses raise a one-cycle err pulse.
//
// Optional feature macro: MAILBOX_AUTO_ACK_EN
//   When defined, a valid read of the last slot (msg_len-1) while the consumer
//   owns the mailbox also releases it, exactly as if ack were asserted.
//
// Parameters
//   DATA_WIDTH     message word width (1..64)
//   MESSAGE_DEPTH  number of message slots (1..256)
//   SEL_W          derived slot select width, max(1, clog2(MESSAGE_DEPTH))
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   wr        in   producer write strobe
//   wr_sel    in   producer slot index
//   wdata     in   producer write data
//   wr_ready  out  producer owns the mailbox (combinational from state)
//   post      in   doorbell, hands the message to the consumer
//   rd        in   consumer read strobe
//   rd_sel    in   consumer slot index
//   rdata     out  registered read data, zero whenever rvalid is low
//   rvalid    out  one-cycle pulse qualifying rdata
//   ack       in   consumer releases the mailbox
//   msg_len   out  highest written slot index + 1 for the current message
//   irq       out  level interrupt, high while the consumer owns the mailbox
//   err       out  registered one-cycle pulse on any rejected access
module mailbox_msg #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int MESSAGE_DEPTH = 8,
  localparam int SEL_W         = (MESSAGE_DEPTH > 1) ? $clog2(MESSAGE_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wr_ready,
  input  logic                  post,
  input  logic                  rd,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  ack,
  output logic [SEL_W:0]        msg_len,
  output logic                  irq,
  output logic                  err
);

  typedef enum logic {EMPTY, POSTED} state_t;

  localparam logic [SEL_W:0] DEPTH_L = (SEL_W+1)'(MESSAGE_DEPTH);
  localparam logic [SEL_W:0] ONE_L   = (SEL_W+1)'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [MESSAGE_DEPTH];

  logic                  wr_in_range;
  logic                  wr_ok;
  logic [SEL_W:0]        wr_len;
  logic [SEL_W:0]        len_upd;
  logic                  rd_ok;
  logic                  post_ok;
  logic                  auto_rel;
  logic                  release_now;
  logic                  err_now;

  assign wr_ready = (state == EMPTY);

  always_comb begin
    wr_in_range = ({1'b0, wr_sel} < DEPTH_L);
    wr_ok       = wr && (state == EMPTY) && wr_in_range;
    wr_len      = {1'b0, wr_sel} + ONE_L;
    // Length including a same-cycle write, so write+post posts that word too.
    len_upd     = (wr_ok && (wr_len > msg_len)) ? wr_len : msg_len;
    rd_ok       = rd && (state == POSTED) && ({1'b0, rd_sel} < msg_len);
    post_ok     = post && (state == EMPTY) && (len_upd != '0);
`ifdef MAILBOX_AUTO_ACK_EN
    auto_rel    = rd_ok && ({1'b0, rd_sel} == (msg_len - ONE_L));
`else
    auto_rel    = 1'b0;
`endif
    release_now = (state == POSTED) && (ack || auto_rel);
    err_now     = (wr && (state == POSTED))
                || (wr && (state == EMPTY) && !wr_in_range)
                || (post && (state == EMPTY) && (len_upd == '0))
                || (rd && !rd_ok);
  end

  // Control and read-return stage: state, length, irq, err and read pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      msg_len <= '0;
      irq     <= 1'b0;
      err     <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      err    <= err_now;
      rvalid <= rd_ok;
      rdata  <= rd_ok ? mem[rd_sel] : '0;
      case (state)
        EMPTY: begin
          msg_len <= len_upd;
          if (post_ok) begin
            state <= POSTED;
            irq   <= 1'b1;
          end
        end
        POSTED: begin
          if (release_now) begin
            state   <= EMPTY;
            irq     <= 1'b0;
            msg_len <= '0;
          end
        end
        default: begin
          state   <= EMPTY;
          irq     <= 1'b0;
          msg_len <= '0;
        end
      endcase
    end
  end

  // Slot storage: no reset, contents survive reset and ack; msg_len gates reads.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_sel] <= wdata;
    end
  end

endmodule

// File: tb/tb_mailbox_msg.sv
// Directed self-checking bench for mailbox_msg: an 8-slot instance exercises
// the message flow, ownership, range errors, simultaneity and reset; a 5-slot
// instance covers out-of-range write indices on a non-power-of-two depth.
module tb_mailbox_msg;

`ifdef MAILBOX_AUTO_ACK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr, post, rd, ack;
  logic [2:0]  wr_sel, rd_sel;
  logic [31:0] wdata, rdata;
  logic        wr_ready, rvalid, irq, err;
  logic [3:0]  msg_len;

  logic        d5_wr, d5_post, d5_rd, d5_ack;
  logic [2:0]  d5_wr_sel, d5_rd_sel;
  logic [31:0] d5_wdata, d5_rdata;
  logic        d5_wr_ready, d5_rvalid, d5_irq, d5_err;
  logic [3:0]  d5_msg_len;

  int checks = 0;
  int errors = 0;

  logic [2:0]  rd_order [3];
  logic [31:0] rd_exp   [3];

  always #5 clk = ~clk;

  mailbox_msg #(.DATA_WIDTH(32), .MESSAGE_DEPTH(8)) u_dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_sel(wr_sel), .wdata(wdata),
    .wr_ready(wr_ready), .post(post), .rd(rd), .rd_sel(rd_sel),
    .rdata(rdata), .rvalid(rvalid), .ack(ack), .msg_len(msg_len),
    .irq(irq), .err(err)
  );

  mailbox_msg #(.DATA_WIDTH(32), .MESSAGE_DEPTH(5)) u_dut5 (
    .clk(clk), .reset(reset), .wr(d5_wr), .wr_sel(d5_wr_sel), .wdata(d5_wdata),
    .wr_ready(d5_wr_ready), .post(d5_post), .rd(d5_rd), .rd_sel(d5_rd_sel),
    .rdata(d5_rdata), .rvalid(d5_rvalid), .ack(d5_ack), .msg_len(d5_msg_len),
    .irq(d5_irq), .err(d5_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr = 1'b0; post = 1'b0; rd = 1'b0; ack = 1'b0;
    wr_sel = '0; rd_sel = '0; wdata = '0;
    d5_wr = 1'b0; d5_post = 1'b0; d5_rd = 1'b0; d5_ack = 1'b0;
    d5_wr_sel = '0; d5_rd_sel = '0; d5_wdata = '0;
  endtask

  // One clock: inputs already set are sampled on this edge; outputs checked #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if (AUTO) begin
      rd_order[0] = 3'd0; rd_order[1] = 3'd1; rd_order[2] = 3'd2;
      rd_exp[0] = 32'hA0; rd_exp[1] = 32'hA1; rd_exp[2] = 32'hA2;
    end else begin
      rd_order[0] = 3'd2; rd_order[1] = 3'd0; rd_order[2] = 3'd1;
      rd_exp[0] = 32'hA2; rd_exp[1] = 32'hA0; rd_exp[2] = 32'hA1;
    end

    // Reset values
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_rdata",    64'(rdata),    64'd0);
    chk("rst_rvalid",   64'(rvalid),   64'd0);
    chk("rst_msg_len",  64'(msg_len),  64'd0);
    chk("rst_irq",      64'(irq),      64'd0);
    chk("rst_err",      64'(err),      64'd0);

    // Read while EMPTY
    rd = 1'b1; rd_sel = 3'd0;
    tick(); idle();
    chk("rd_empty_err",    64'(err),    64'd1);
    chk("rd_empty_rvalid", 64'(rvalid), 64'd0);

    // Post with no words written
    post = 1'b1;
    tick(); idle();
    chk("post_empty_err",   64'(err),      64'd1);
    chk("post_empty_irq",   64'(irq),      64'd0);
    chk("post_empty_ready", 64'(wr_ready), 64'd1);
    tick();
    chk("err_one_cycle", 64'(err), 64'd0);

    // Fill slots 0..2
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wr_sel = 3'(i); wdata = 32'hA0 + 32'(i);
      tick(); idle();
      chk("wr_err", 64'(err), 64'd0);
    end
    chk("len_after_wr", 64'(msg_len), 64'd3);

    post = 1'b1;
    tick(); idle();
    chk("posted_irq",   64'(irq),      64'd1);
    chk("posted_ready", 64'(wr_ready), 64'd0);
    chk("posted_len",   64'(msg_len),  64'd3);

    // Ownership violation: write while consumer owns
    wr = 1'b1; wr_sel = 3'd0; wdata = 32'hDEAD;
    tick(); idle();
    chk("own_viol_err", 64'(err), 64'd1);

    // Post while POSTED is silently ignored
    post = 1'b1;
    tick(); idle();
    chk("repost_err", 64'(err), 64'd0);
    chk("repost_irq", 64'(irq), 64'd1);

    // Read beyond msg_len
    rd = 1'b1; rd_sel = 3'd3;
    tick(); idle();
    chk("rd_range_err",    64'(err),    64'd1);
    chk("rd_range_rvalid", 64'(rvalid), 64'd0);
    chk("rd_range_rdata",  64'(rdata),  64'd0);

    // Back-to-back reads
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; rd_sel = rd_order[i];
      tick();
      chk("b2b_rvalid", 64'(rvalid), 64'd1);
      chk("b2b_rdata",  64'(rdata),  64'(rd_exp[i]));
      chk("b2b_err",    64'(err),    64'd0);
    end
    idle();
    chk("last_rd_irq", 64'(irq), AUTO ? 64'd0 : 64'd1);

    ack = 1'b1;
    tick(); idle();
    chk("ack_irq",    64'(irq),      64'd0);
    chk("ack_ready",  64'(wr_ready), 64'd1);
    chk("ack_len",    64'(msg_len),  64'd0);
    chk("ack_err",    64'(err),      64'd0);
    chk("ack_rvalid", 64'(rvalid),   64'd0);
    chk("ack_rdata",  64'(rdata),    64'd0);

    // Ack in EMPTY is ignored without error
    ack = 1'b1;
    tick(); idle();
    chk("ack_empty_err", 64'(err), 64'd0);

    // New message touching only slot 1; slot 0 must still hold 0xA0
    wr = 1'b1; wr_sel = 3'd1; wdata = 32'hB1;
    tick(); idle();
    chk("msg2_len", 64'(msg_len), 64'd2);
    post = 1'b1;
    tick(); idle();
    chk("msg2_irq", 64'(irq), 64'd1);
    rd = 1'b1; rd_sel = 3'd0;
    tick(); idle();
    chk("slot0_kept_rvalid", 64'(rvalid), 64'd1);
    chk("slot0_kept_rdata",  64'(rdata),  64'hA0);
    rd = 1'b1; rd_sel = 3'd1;
    tick(); idle();
    chk("msg2_rd1_rdata", 64'(rdata), 64'hB1);
    chk("auto_ack_irq",   64'(irq),   AUTO ? 64'd0 : 64'd1);
    ack = 1'b1;
    tick(); idle();
    chk("msg2_ack_irq", 64'(irq),     64'd0);
    chk("msg2_ack_len", 64'(msg_len), 64'd0);

    // Write together with post includes the write
    wr = 1'b1; wr_sel = 3'd4; wdata = 32'h44; post = 1'b1;
    tick(); idle();
    chk("wrpost_len", 64'(msg_len), 64'd5);
    chk("wrpost_irq", 64'(irq),     64'd1);
    chk("wrpost_err", 64'(err),     64'd0);
    rd = 1'b1; rd_sel = 3'd0;
    tick(); idle();
    chk("wrpost_rd0", 64'(rdata), 64'hA0);

    // Read together with ack
    rd = 1'b1; rd_sel = 3'd4; ack = 1'b1;
    tick(); idle();
    chk("rdack_rvalid", 64'(rvalid),   64'd1);
    chk("rdack_rdata",  64'(rdata),    64'h44);
    chk("rdack_irq",    64'(irq),      64'd0);
    chk("rdack_ready",  64'(wr_ready), 64'd1);
    chk("rdack_len",    64'(msg_len),  64'd0);

    // Reset mid-message with a read pending
    wr = 1'b1; wr_sel = 3'd2; wdata = 32'hC2; post = 1'b1;
    tick(); idle();
    chk("pre_rst_irq", 64'(irq), 64'd1);
    rd = 1'b1; rd_sel = 3'd0; reset = 1'b1;
    tick(); idle();
    reset = 1'b0;
    chk("midrst_rvalid", 64'(rvalid),   64'd0);
    chk("midrst_rdata",  64'(rdata),    64'd0);
    chk("midrst_irq",    64'(irq),      64'd0);
    chk("midrst_len",    64'(msg_len),  64'd0);
    chk("midrst_ready",  64'(wr_ready), 64'd1);

    // Non-power-of-two depth: out-of-range write index
    d5_wr = 1'b1; d5_wr_sel = 3'd6; d5_wdata = 32'h66;
    tick(); idle();
    chk("d5_oob_err", 64'(d5_err),     64'd1);
    chk("d5_oob_len", 64'(d5_msg_len), 64'd0);
    d5_wr = 1'b1; d5_wr_sel = 3'd4; d5_wdata = 32'h55;
    tick(); idle();
    chk("d5_top_err", 64'(d5_err),     64'd0);
    chk("d5_top_len", 64'(d5_msg_len), 64'd5);
    d5_post = 1'b1;
    tick(); idle();
    d5_rd = 1'b1; d5_rd_sel = 3'd4;
    tick(); idle();
    chk("d5_rd_rvalid", 64'(d5_rvalid), 64'd1);
    chk("d5_rd_rdata",  64'(d5_rdata),  64'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mailbox_msg.md
# mailbox_msg

Parametrised single-direction message mailbox between a producer (e.g. FPGA fabric master) and a consumer (e.g. MSS hart via APB/AXI-lite register shim). The producer fills up to MESSAGE_DEPTH words, then rings a doorbell. Ownership passes to the consumer, who is signalled by a level interrupt and reads with a registered, one-cycle-latency port. An acknowledge returns ownership to the producer. Ownership, message length and error tracking are new relative to the plain always-ready mailbox register bank.

## Interface
- DATA_WIDTH, 32, message word width (1..64)
- MESSAGE_DEPTH, 8, number of message slots (1..256)
- SEL_W, derived = max(1, $clog2(MESSAGE_DEPTH)), slot select width; not overridable
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr  in  1  producer write strobe
- wr_sel  in  SEL_W  producer slot index
- wdata  in  DATA_WIDTH  producer write data
- wr_ready  out  1  producer owns mailbox; writes accepted
- post  in  1  doorbell; hands message to consumer
- rd  in  1  consumer read strobe
- rd_sel  in  SEL_W  consumer slot index
- rdata  out  DATA_WIDTH  read data, registered
- rvalid  out  1  rdata valid, one-cycle pulse
- ack  in  1  consumer releases mailbox
- msg_len  out  SEL_W+1  slots in current message (highest written index + 1)
- irq  out  1  level interrupt, high while consumer owns mailbox
- err  out  1  one-cycle pulse on any rejected access

## Operation
- State machine: EMPTY (producer owns) and POSTED (consumer owns). Reset enters EMPTY.
- EMPTY:
  - wr_ready=1.
  - wr with wr_sel<MESSAGE_DEPTH writes the slot and sets msg_len <= max(msg_len, wr_sel+1).
  - post with msg_len>0 (after including a same-cycle write) moves to POSTED.
  - post with msg_len==0 is ignored and pulses err.
- POSTED:
  - wr_ready=0 and irq=1.
  - wr is dropped (slot unchanged) and pulses err. post is ignored without error.
  - rd with rd_sel<msg_len returns the slot.
  - ack moves to EMPTY and clears msg_len to 0.
- rd in EMPTY, or rd_sel>=msg_len, gives no rvalid and pulses err.
- ack in EMPTY is ignored without error.
- wr_sel>=MESSAGE_DEPTH (non-power-of-two depth) is dropped and pulses err.
- Simultaneous rd and ack in POSTED: the read completes normally, and state is EMPTY the next cycle.
- Simultaneous wr and post in EMPTY: the write is included in the message.
- The slot array has no reset; contents survive reset and ack. msg_len gates all reads.
- err is the OR of all error causes in a cycle, registered.

## Timing
- Reset values: wr_ready=1, rdata=0, rvalid=0, msg_len=0, irq=0, err=0.
- wr_ready is combinational from state. irq and msg_len are registered from state.
- post at cycle N: irq=1 and wr_ready=0 from cycle N+1.
- ack at cycle N: irq=0, wr_ready=1 and msg_len=0 from cycle N+1.
- Reads:
  - rd at cycle N gives rdata/rvalid at cycle N+1.
  - Back-to-back rd every cycle is supported at full throughput.
  - rdata returns to 0 on any cycle where rvalid=0.
- err is asserted the cycle after the offending strobe.
- Reset mid-message: next cycle is EMPTY with msg_len=0. A pending rvalid is squashed.

## Configuration
- MAILBOX_AUTO_ACK_EN defined:
  - In POSTED, a valid rd of slot msg_len-1 also acts as ack in the same cycle.
  - rdata/rvalid for that read still appear at N+1, and irq falls at N+1.
  - An explicit ack remains functional.
- Not defined: only ack releases the mailbox.

## Test plan
- Basic message (DEPTH=8): write slots 0..2 with 0xA0,0xA1,0xA2, then post. Expect msg_len=3 and irq=1 next cycle. Read 2,0,1 back-to-back and expect 0xA2,0xA0,0xA1 on consecutive rvalid cycles. ack gives irq=0, wr_ready=1, msg_len=0.
- Ownership violation: in POSTED, wr slot 0 = 0xDEAD gives err pulse. After ack, post a new 1-word message, read slot 0, and expect 0xA0 (unchanged).
- Range errors:
  - rd_sel=3 with msg_len=3 gives err and no rvalid.
  - rd in EMPTY gives err.
  - post with msg_len=0 gives err and stays EMPTY.
  - With DEPTH=5, wr_sel=6 gives err.
- Simultaneity:
  - wr slot 4 = 0x44 together with post gives msg_len=5, and reading slot 4 returns 0x44.
  - rd slot 0 together with ack gives rvalid at N+1 and irq=0 at N+1.
- Reset mid-operation: in POSTED, assert rd then reset in the same cycle. Expect rvalid=0, irq=0, msg_len=0, wr_ready=1.
- With MAILBOX_AUTO_ACK_EN: post msg_len=2, read slot 1. Expect rvalid with data and irq=0 at N+1 with no ack. Without the macro, irq stays 1.
